// File: rtl/speed_test_sequencer.sv
// ---------------------------------------------------------------------------
// speed_test_sequencer
//
// Runs one measurement on an external ring-oscillator speed-test macro:
// reset it, arm the oscillators, check the fired flag is clear, pulse the
// trigger, wait for the fired flag, read back two 24-bit down-counters one
// byte at a time, and present the converted tick counts plus error flags.
//
// Ports
//   clk          in   system clock, rising edge
//   nrst         in   asynchronous active-low reset
//   start        in   one-cycle run request, honoured only in IDLE
//   dut_out[7:0] in   macro output; with dut_sel=111 bit 6 is the fired flag,
//                     otherwise the whole byte is the selected count byte
//   dut_nrst     out  macro reset, active-low
//   dut_trig     out  macro trigger
//   dut_sel[2:0] out  macro readout select
//   dut_ring_en  out  ring oscillator enables
//   busy         out  high in every state except IDLE and DONE
//   res_valid    out  result available
//   res_ready    in   result consumed
//   ticks0/1     out  24'hFFFFFF minus the raw counts
//   err[4:0]     out  {overflow, mismatch, too_small, timeout, fired_stuck}
//   dbg_state    out  current FSM state encoding, for checkers
//
// Result handshake: the result is offered while res_valid=1 (state DONE);
// it is transferred at a rising edge where res_valid and res_ready are both
// high. ticks0/ticks1/err never change while res_valid=1 and keep their
// value in IDLE until the next run enters DRST.
// ---------------------------------------------------------------------------
module speed_test_sequencer #(
  parameter int TRIG_CYCLES = 2,
  parameter int TIMEOUT     = 16,
  parameter int MAX_DIFF    = 3
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [7:0]  dut_out,
  output logic        dut_nrst,
  output logic        dut_trig,
  output logic [2:0]  dut_sel,
  output logic [1:0]  dut_ring_en,
  output logic        busy,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [23:0] ticks0,
  output logic [23:0] ticks1,
  output logic [4:0]  err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRST  = 3'd1,
    S_ARM   = 3'd2,
    S_CHECK = 3'd3,
    S_TRIG  = 3'd4,
    S_WAIT  = 3'd5,
    S_READ  = 3'd6,
    S_DONE  = 3'd7
  } state_e;

  localparam int             CW         = 16;
  localparam logic [CW-1:0]  TRIG_LAST  = CW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0]  WAIT_LAST  = CW'(TIMEOUT - 1);
  // 6 bytes x 2 cycles each
  localparam logic [CW-1:0]  READ_LAST  = CW'(11);
  localparam logic [23:0]    DIFF_LIMIT = 24'(MAX_DIFF);
  localparam logic [23:0]    MIN_COUNT  = 24'd10;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [23:0]   count0_q, count0_d;
  logic [23:0]   count1_q, count1_d;
  logic [23:0]   ticks0_q, ticks0_d;
  logic [23:0]   ticks1_q, ticks1_d;
  logic [4:0]    err_q, err_d;
  logic [23:0]   diff;
  logic          fired;

  // Fired flag is only meaningful while dut_sel=111 (ARM through WAIT).
  assign fired = dut_out[6];

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      count0_q <= '0;
      count1_q <= '0;
      ticks0_q <= '0;
      ticks1_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      count0_q <= count0_d;
      count1_q <= count1_d;
      ticks0_q <= ticks0_d;
      ticks1_q <= ticks1_d;
      err_q    <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath update
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    count0_d = count0_q;
    count1_d = count1_q;
    ticks0_d = ticks0_q;
    ticks1_d = ticks1_q;
    err_d    = err_q;
    diff     = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Previous result is dropped as the new run begins.
          state_d  = S_DRST;
          cnt_d    = '0;
          count0_d = '0;
          count1_d = '0;
          ticks0_d = '0;
          ticks1_d = '0;
          err_d    = '0;
        end
      end

      S_DRST: state_d = S_ARM;

      S_ARM: state_d = S_CHECK;

      S_CHECK: begin
        if (fired) begin
          // Flag already set before any trigger: macro is not trustworthy.
          err_d[0] = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_TRIG;
          cnt_d   = '0;
        end
      end

      S_TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT: begin
        if (fired) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else if (cnt_q == WAIT_LAST) begin
          err_d[1] = 1'b1;
          state_d  = S_DONE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_READ: begin
        cnt_d = cnt_q + 1'b1;
        // Even cycles put the new select on the bus; odd cycles end with the
        // capture edge, giving the macro a full cycle of settling time.
        if (cnt_q[0]) begin
          case (cnt_q[3:1])
            3'd0:    count0_d[7:0]   = dut_out;
            3'd1:    count0_d[15:8]  = dut_out;
            3'd2:    count0_d[23:16] = dut_out;
            3'd3:    count1_d[7:0]   = dut_out;
            3'd4:    count1_d[15:8]  = dut_out;
            default: count1_d[23:16] = dut_out;
          endcase
        end
        if (cnt_q == READ_LAST) begin
          // count1_d already holds the byte captured on this final edge.
          state_d  = S_DONE;
          cnt_d    = '0;
          ticks0_d = 24'hFFFFFF - count0_d;
          ticks1_d = 24'hFFFFFF - count1_d;
          diff     = (count0_d > count1_d) ? (count0_d - count1_d)
                                           : (count1_d - count0_d);
          err_d[2] = (count0_d < MIN_COUNT) || (count1_d < MIN_COUNT);
          err_d[3] = (diff > DIFF_LIMIT);
          // Down-counters start at all-ones; a cleared MSB means they wrapped.
          err_d[4] = !count0_d[23] || !count1_d[23];
        end
      end

      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs decoded from state (so reset reaches them asynchronously)
  // -------------------------------------------------------------------------
  always_comb begin
    dut_nrst    = 1'b1;
    dut_trig    = 1'b0;
    dut_sel     = 3'b000;
    dut_ring_en = 2'b00;
    busy        = 1'b1;
    res_valid   = 1'b0;

    case (state_q)
      S_IDLE: begin
        dut_nrst = 1'b0;
        busy     = 1'b0;
      end
      S_DRST: dut_nrst = 1'b0;
      S_ARM, S_CHECK, S_WAIT: begin
        dut_sel     = 3'b111;
        dut_ring_en = 2'b11;
      end
      S_TRIG: begin
        dut_sel     = 3'b111;
        dut_ring_en = 2'b11;
        dut_trig    = 1'b1;
      end
      S_READ: begin
        // Byte index 0..5 maps to 000,001,010 (count0) and 100,101,110 (count1).
        case (cnt_q[3:1])
          3'd0:    dut_sel = 3'b000;
          3'd1:    dut_sel = 3'b001;
          3'd2:    dut_sel = 3'b010;
          3'd3:    dut_sel = 3'b100;
          3'd4:    dut_sel = 3'b101;
          default: dut_sel = 3'b110;
        endcase
      end
      S_DONE: begin
        busy      = 1'b0;
        res_valid = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign ticks0    = ticks0_q;
  assign ticks1    = ticks1_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
